tube_scan_controller: RTL

- Time-multiplexes NUM_DIGITS BCD digits onto one shared 7-segment decoder and a common segment bus.
- Each digit slot is a blanking interval (anti-ghosting) followed by a drive interval; only one digit select is active at a time.
- Digit data is captured into a shadow register only at frame boundaries, via a req/ack handshake, so a frame never tears.
- Sits between the traffic-light timing logic (countdown values) and the tube decoder, driving its DecimalValue input.

---
 rtl/tube_scan_controller.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/tube_scan_controller.sv
// -----------------------------------------------------------------------------
// tube_scan_controller
// Time-multiplexes NUM_DIGITS BCD digits onto one shared 7-segment decoder.
// Every digit slot is BLANK_CYC cycles of blanking (anti-ghosting) followed by
// DRIVE_CYC cycles of drive. Digit data is taken into a shadow register only
// at the frame boundary (digit index wrap), so a displayed frame never tears.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   DigitsIn      BCD digits, [3:0] = digit 0 (least significant)
//   LoadReq       capture request, level sampled at the frame boundary edge
//   LoadAck       one-cycle pulse: shadow register was updated
//   LzbEn         leading-zero blanking enable (sampled every cycle)
//   BlinkMask     per-digit blink enable (only with TUBE_BLINK_EN)
//   DecimalValue  digit value to the tube decoder, 4'hF = blank
//   DigitSel      active-low one-hot tube select
//   FrameStart    one-cycle pulse on the first cycle of each new frame
//
// Optional feature macro: TUBE_BLINK_EN adds BlinkMask and a frame counter
// that toggles a blink phase every BLINK_FRAMES frame boundaries.
// All outputs are registers; no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module tube_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYC    = 16,
    parameter int DRIVE_CYC    = 4096,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] DigitsIn,
    input  logic                    LoadReq,
    output logic                    LoadAck,
    input  logic                    LzbEn,
`ifdef TUBE_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   BlinkMask,
`endif
    output logic [3:0]              DecimalValue,
    output logic [NUM_DIGITS-1:0]   DigitSel,
    output logic                    FrameStart
);

    localparam int CNT_MAX = (DRIVE_CYC > BLANK_CYC) ? DRIVE_CYC : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || BLANK_CYC < 1 || DRIVE_CYC < 1 ||
        BLINK_FRAMES < 1) begin : g_bad_params
        $error("tube_scan_controller: illegal parameter value");
    end

    logic [0:0]              state_r, state_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic [IDX_W-1:0]        idx_r, idx_s;
    logic [4*NUM_DIGITS-1:0] shadow_r, shadow_s;
    logic                    wrap_s;
    logic                    capture_s;
    logic                    zero_run_s;
    logic [NUM_DIGITS-1:0]   lead_zero_s;
    logic [NUM_DIGITS-1:0]   blink_hide_s;
    logic [NUM_DIGITS-1:0]   hide_s;
    logic [3:0]              digit_s;
    logic [3:0]              dec_s;
    logic [NUM_DIGITS-1:0]   sel_s;

    // Slot sequencer: blank/drive phases, digit index advance and frame wrap.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r + CNT_W'(1);
        idx_s   = idx_r;
        wrap_s  = 1'b0;
        case (state_r)
            ST_BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    state_s = ST_DRIVE;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_BLANK;
                end
            end
            ST_DRIVE: begin
                if (cnt_r == DRIVE_LAST) begin
                    state_s = ST_BLANK;
                    cnt_s   = {CNT_W{1'b0}};
                    if (idx_r == IDX_LAST) begin
                        idx_s  = {IDX_W{1'b0}};
                        wrap_s = 1'b1;
                    end else begin
                        idx_s  = idx_r + IDX_W'(1);
                    end
                end else begin
                    state_s = ST_DRIVE;
                end
            end
            default: begin
                state_s = ST_BLANK;
                cnt_s   = {CNT_W{1'b0}};
                idx_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Shadow capture happens only on the wrap edge, so a frame never tears.
    always_comb begin
        capture_s = wrap_s & LoadReq;
        if (capture_s) begin
            shadow_s = DigitsIn;
        end else begin
            shadow_s = shadow_r;
        end
    end

    // Leading-zero flags: digit i>0 is a leading zero when it and every more
    // significant digit are zero. Scanned from the top digit downwards.
    always_comb begin
        zero_run_s  = 1'b1;
        lead_zero_s = {NUM_DIGITS{1'b0}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run_s     = zero_run_s & (shadow_s[4*i +: 4] == 4'h0);
            lead_zero_s[i] = (i != 0) ? zero_run_s : 1'b0;
        end
    end

`ifdef TUBE_BLINK_EN
    localparam int FRM_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [FRM_W-1:0] frame_r, frame_s;
    logic             phase_on_r, phase_on_s;

    // Blink phase flips after every BLINK_FRAMES frame boundaries.
    always_comb begin
        frame_s    = frame_r;
        phase_on_s = phase_on_r;
        if (wrap_s) begin
            if (frame_r == FRM_LAST) begin
                frame_s    = {FRM_W{1'b0}};
                phase_on_s = ~phase_on_r;
            end else begin
                frame_s    = frame_r + FRM_W'(1);
            end
        end else begin
            frame_s    = frame_r;
        end
        blink_hide_s = phase_on_s ? {NUM_DIGITS{1'b0}} : BlinkMask;
    end

    // Blink frame counter and phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_r    <= {FRM_W{1'b0}};
            phase_on_r <= 1'b1;
        end else begin
            frame_r    <= frame_s;
            phase_on_r <= phase_on_s;
        end
    end
`else
    // Without blinking no digit is ever hidden for blink reasons.
    always_comb begin
        blink_hide_s = {NUM_DIGITS{1'b0}};
    end
`endif

    // Output decode from the next state so outputs stay registered.
    always_comb begin
        hide_s  = (LzbEn ? lead_zero_s : {NUM_DIGITS{1'b0}}) | blink_hide_s;
        digit_s = shadow_s[4*idx_s +: 4];
        dec_s   = 4'hF;
        sel_s   = {NUM_DIGITS{1'b1}};
        if (state_s == ST_DRIVE && !hide_s[idx_s]) begin
            dec_s        = digit_s;
            sel_s[idx_s] = 1'b0;
        end else begin
            dec_s = 4'hF;
            sel_s = {NUM_DIGITS{1'b1}};
        end
    end

    // State, shadow and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_BLANK;
            cnt_r        <= {CNT_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            shadow_r     <= {(4*NUM_DIGITS){1'b0}};
            LoadAck      <= 1'b0;
            FrameStart   <= 1'b0;
            DecimalValue <= 4'hF;
            DigitSel     <= {NUM_DIGITS{1'b1}};
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            idx_r        <= idx_s;
            shadow_r     <= shadow_s;
            LoadAck      <= capture_s;
            FrameStart   <= wrap_s;
            DecimalValue <= dec_s;
            DigitSel     <= sel_s;
        end
    end

endmodule
